// File: rtl/hazard_pkg.sv
// Shared types and sizing helpers for the pipeline hazard controller.
package hazard_pkg;

   localparam int REG_ADDR_W_DEF = 5;
   localparam int MC_CYCLES_DEF  = 4;
   localparam int MC_CNT_W       = $clog2(MC_CYCLES_DEF);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MC_BUSY = 2'd1,
      MC_DONE = 2'd2
   } hz_state_t;

   // Counter width for a given multi-cycle latency.
   function automatic int mc_cnt_w(input int mc_cycles);
      return $clog2(mc_cycles);
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: flags a decode-stage read of a register that the
// load currently in EX has not yet produced. Writes to x0 never stall.
module load_use_detect #(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_reg_write,
   input  logic                  ex_is_load,
   output logic                  lu_stall
);

   logic rd_live;
   logic rs1_hit;
   logic rs2_hit;

   // Compare both decode sources against the pending load destination.
   always_comb begin
      rd_live  = ex_is_load & ex_reg_write & (ex_rd != '0);
      rs1_hit  = id_rs1_used & (id_rs1 == ex_rd);
      rs2_hit  = id_rs2_used & (id_rs2 == ex_rd);
      lu_stall = rd_live & (rs1_hit | rs2_hit);
   end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the 5-stage pipeline. Drives PC hold and the
// hold/clear pins of IF/ID, ID/EX and the clear of EX/MEM.
// Optional build macro HAZARD_PERF_EN adds stall-cycle and flush counters;
// without it stall_cycles and flush_count are constant 0.
//
// state   | meaning
// --------+-------------------------------------------------------------
// RUN     | normal flow; load-use stalls and branch flushes resolved here
// MC_BUSY | multi-cycle op occupying EX; front end frozen, MEM gets bubbles
// MC_DONE | last EX cycle of the op; result advances, normal rules apply
module hazard_control_unit
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int MC_CYCLES  = MC_CYCLES_DEF
) (
   input  logic                  clk,
   input  logic                  clear_n,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_reg_write,
   input  logic                  ex_is_load,
   input  logic                  ex_branch_taken,
   input  logic                  ex_mc_start,
   output logic                  pc_hold,
   output logic                  ifid_hold,
   output logic                  ifid_clear,
   output logic                  idex_hold,
   output logic                  idex_clear,
   output logic                  exmem_clear,
   output logic                  mc_busy,
   output logic [31:0]           stall_cycles,
   output logic [31:0]           flush_count
);

   localparam int CNT_W = mc_cnt_w(MC_CYCLES);

   hz_state_t        state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             lu_stall;

   load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lud (
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_rs1_used  (id_rs1_used),
      .id_rs2_used  (id_rs2_used),
      .ex_rd        (ex_rd),
      .ex_reg_write (ex_reg_write),
      .ex_is_load   (ex_is_load),
      .lu_stall     (lu_stall)
   );

   // Next-state and same-cycle control outputs; branch beats everything
   // outside MC_BUSY, and mc start beats load-use in RUN.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      ifid_clear  = 1'b0;
      idex_hold   = 1'b0;
      idex_clear  = 1'b0;
      exmem_clear = 1'b0;
      mc_busy     = 1'b0;
      if (!clear_n) begin
         ifid_clear  = 1'b1;
         idex_clear  = 1'b1;
         exmem_clear = 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (ex_branch_taken) begin
                  ifid_clear = 1'b1;
                  idex_clear = 1'b1;
               end else if (ex_mc_start) begin
                  pc_hold     = 1'b1;
                  ifid_hold   = 1'b1;
                  idex_hold   = 1'b1;
                  exmem_clear = 1'b1;
                  mc_busy     = 1'b1;
                  if (MC_CYCLES == 2) begin
                     state_nxt = MC_DONE;
                  end else begin
                     state_nxt = MC_BUSY;
                     cnt_nxt   = CNT_W'(MC_CYCLES - 3);
                  end
               end else if (lu_stall) begin
                  pc_hold    = 1'b1;
                  ifid_hold  = 1'b1;
                  idex_clear = 1'b1;
               end
            end
            MC_BUSY: begin
               pc_hold     = 1'b1;
               ifid_hold   = 1'b1;
               idex_hold   = 1'b1;
               exmem_clear = 1'b1;
               mc_busy     = 1'b1;
               if (cnt == '0) begin
                  state_nxt = MC_DONE;
               end else begin
                  cnt_nxt = cnt - CNT_W'(1);
               end
            end
            MC_DONE: begin
               state_nxt = RUN;
               if (ex_branch_taken) begin
                  ifid_clear = 1'b1;
                  idex_clear = 1'b1;
               end else if (lu_stall) begin
                  pc_hold    = 1'b1;
                  ifid_hold  = 1'b1;
                  idex_clear = 1'b1;
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   // State and latency counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!clear_n) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_q;
   logic [31:0] flush_q;

   // Performance counters; ifid_clear outside reset only occurs on a flush.
   always_ff @(posedge clk) begin
      if (!clear_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (pc_hold)    stall_q <= stall_q + 32'd1;
         if (ifid_clear) flush_q <= flush_q + 32'd1;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit (MC_CYCLES=4): the driver pushes
// hand-computed expected controls per cycle, the monitor pops and compares.
module tb_hazard_control_unit;

   logic        clk;
   logic        clear_n;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_rs1_used, id_rs2_used;
   logic        ex_reg_write, ex_is_load, ex_branch_taken, ex_mc_start;
   logic        pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear;
   logic        exmem_clear, mc_busy;
   logic [31:0] stall_cycles, flush_count;

   // {pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear, exmem_clear, mc_busy}
   localparam logic [6:0] NONE = 7'b0000000;
   localparam logic [6:0] RST  = 7'b0010110;
   localparam logic [6:0] LU   = 7'b1100100;
   localparam logic [6:0] FL   = 7'b0010100;
   localparam logic [6:0] MC   = 7'b1101011;

   typedef struct {
      logic [6:0]  ctl;
      logic [31:0] stall;
      logic [31:0] flush;
      string       nm;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] m_stall = 0;
   logic [31:0] m_flush = 0;

   hazard_control_unit #(.REG_ADDR_W(5), .MC_CYCLES(4)) dut (
      .clk             (clk),
      .clear_n         (clear_n),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_rs1_used     (id_rs1_used),
      .id_rs2_used     (id_rs2_used),
      .ex_rd           (ex_rd),
      .ex_reg_write    (ex_reg_write),
      .ex_is_load      (ex_is_load),
      .ex_branch_taken (ex_branch_taken),
      .ex_mc_start     (ex_mc_start),
      .pc_hold         (pc_hold),
      .ifid_hold       (ifid_hold),
      .ifid_clear      (ifid_clear),
      .idex_hold       (idex_hold),
      .idex_clear      (idex_clear),
      .exmem_clear     (exmem_clear),
      .mc_busy         (mc_busy),
      .stall_cycles    (stall_cycles),
      .flush_count     (flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stimulus must never present a taken branch together with an mc start.
   always @(posedge clk) begin
      if (clear_n) assert (!(ex_branch_taken && ex_mc_start))
         else $error("protocol violation: branch with mc start");
   end

   task automatic step(input string nm, input logic cn,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic rw, input logic ld,
                       input logic br, input logic mc, input logic [6:0] exp);
      exp_t e;
      @(posedge clk);
      #1;
      clear_n = cn; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2;
      id_rs2_used = u2; ex_rd = rd; ex_reg_write = rw; ex_is_load = ld;
      ex_branch_taken = br; ex_mc_start = mc;
      e.ctl = exp; e.stall = m_stall; e.flush = m_flush; e.nm = nm;
      sb.push_back(e);
`ifdef HAZARD_PERF_EN
      if (!cn) begin
         m_stall = 0;
         m_flush = 0;
      end else begin
         if (exp[6]) m_stall = m_stall + 1;
         if (exp[4]) m_flush = m_flush + 1;
      end
`endif
   endtask

   // Monitor: controls are combinational, so one expectation per cycle.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         logic [6:0] act;
         e = sb.pop_front();
         act = {pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear,
                exmem_clear, mc_busy};
         checks++;
         if (act !== e.ctl) begin
            errors++;
            $display("FAIL %s ctl: got %b want %b", e.nm, act, e.ctl);
         end
         checks++;
         if (stall_cycles !== e.stall || flush_count !== e.flush) begin
            errors++;
            $display("FAIL %s counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                     e.nm, stall_cycles, flush_count, e.stall, e.flush);
         end
      end
   end

   initial begin
      int budget;
      clear_n = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
      id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_reg_write = 1'b0;
      ex_is_load = 1'b0; ex_branch_taken = 1'b0; ex_mc_start = 1'b0;
      //    name          cn rs1 u1 rs2 u2 rd rw ld br mc exp
      step("rst0",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST);
      step("rst1",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST);
      step("idle",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);
      step("lu_rs2",      1, 0, 0, 5, 1, 5, 1, 1, 0, 0, LU);
      step("lu_mem",      1, 0, 0, 5, 1, 0, 0, 0, 0, 0, NONE);
      step("lu_rs1",      1, 7, 1, 0, 0, 7, 1, 1, 0, 0, LU);
      step("rs1_unused",  1, 7, 0, 3, 1, 7, 1, 1, 0, 0, NONE);
      step("load_x0",     1, 0, 1, 0, 0, 0, 1, 1, 0, 0, NONE);
      step("load_nowr",   1, 9, 1, 0, 0, 9, 0, 1, 0, 0, NONE);
      step("not_load",    1, 9, 1, 0, 0, 9, 1, 0, 0, 0, NONE);
      step("branch",      1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FL);
      step("br_over_lu",  1, 0, 0, 5, 1, 5, 1, 1, 1, 0, FL);
      step("mc0",         1, 0, 0, 0, 0, 0, 0, 0, 0, 1, MC);
      step("mc1",         1, 0, 0, 0, 0, 0, 0, 0, 0, 1, MC);
      step("mc2",         1, 0, 0, 0, 0, 0, 0, 0, 0, 1, MC);
      step("mc3_done",    1, 0, 0, 0, 0, 0, 0, 0, 0, 1, NONE);
      step("mc4_run",     1, 0, 0, 0, 0, 0, 0, 0, 0, 1, MC);
      step("busy_br",     1, 0, 0, 0, 0, 0, 0, 0, 1, 0, MC);
      step("busy_lu",     1, 0, 0, 5, 1, 5, 1, 1, 0, 0, MC);
      step("done_br",     1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FL);
      step("run_idle",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);
      step("mcb0",        1, 0, 0, 0, 0, 0, 0, 0, 0, 1, MC);
      step("mcb1",        1, 0, 0, 0, 0, 0, 0, 0, 0, 1, MC);
      step("rst_mid",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, RST);
      step("post_rst",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);
      step("post_rst_lu", 1, 4, 1, 0, 0, 4, 1, 1, 0, 0, LU);
      step("tail",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);
      budget = 0;
      while (sb.size() > 0 && budget < 20) begin
         @(posedge clk);
         budget++;
      end
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, want run complete");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Central stall/flush controller for the 5-stage pipeline; sole driver of the hold and clear pins on the IF/ID, ID/EX and EX/MEM buffer registers and of PC hold.
Resolves three hazards:
- load-use stalls
- taken-branch flushes
- multi-cycle execute ops, which freeze the front end for a fixed latency

Holds a small FSM and a down-counter. Sits beside the datapath and observes decode- and execute-stage fields.

Parameters:
REG_ADDR_W, 5, register index width
MC_CYCLES, 4, total cycles a multi-cycle op occupies EX; legal range 2..16

Ports:
clk  input  1  pipeline clock
clear_n  input  1  synchronous active-low reset
id_rs1  input  REG_ADDR_W  decode-stage source 1 index
id_rs2  input  REG_ADDR_W  decode-stage source 2 index
id_rs1_used  input  1  decode instruction reads rs1
id_rs2_used  input  1  decode instruction reads rs2
ex_rd  input  REG_ADDR_W  execute-stage destination index
ex_reg_write  input  1  execute instruction writes ex_rd
ex_is_load  input  1  execute instruction is a load
ex_branch_taken  input  1  branch/jump resolved taken in EX
ex_mc_start  input  1  execute instruction is a multi-cycle op
pc_hold  output  1  freeze PC
ifid_hold  output  1  IF/ID hold
ifid_clear  output  1  IF/ID clear
idex_hold  output  1  ID/EX hold
idex_clear  output  1  ID/EX clear
exmem_clear  output  1  EX/MEM clear (bubble into MEM)
mc_busy  output  1  multi-cycle op in progress
stall_cycles  output  32  stall-cycle count (see Optional Feature)
flush_count  output  32  flush count (see Optional Feature)

Behaviour:
- Interface: single clock clk; reset clear_n is synchronous and active-low. All state updates on posedge clk.
- Control outputs are combinational from current state and inputs, so they act at the same edge as the hazard.

Reset (clear_n=0 at posedge):
- state<=RUN, cnt<=0.
- While clear_n=0: ifid_clear=idex_clear=exmem_clear=1; all holds=0; mc_busy=0.
- Reset mid-multi-cycle aborts the op with no further holds.

FSM states RUN, MC_BUSY, MC_DONE:
- RUN, ex_mc_start=1:
  - outputs: pc_hold=ifid_hold=idex_hold=1, exmem_clear=1, mc_busy=1.
  - next: MC_DONE if MC_CYCLES==2, else MC_BUSY with cnt<=MC_CYCLES-3.
- MC_BUSY:
  - outputs: same as the RUN start cycle.
  - next: MC_DONE if cnt==0, else cnt<=cnt-1.
  - ex_branch_taken and load-use are ignored.
- MC_DONE:
  - outputs: no holds, no clears; EX result advances to MEM.
  - ex_mc_start is ignored (same op still visible).
  - branch and load-use rules apply; next RUN.
- Net effect: the op occupies EX for exactly MC_CYCLES cycles, and the front end is held for MC_CYCLES-1 cycles.

Load-use (RUN or MC_DONE, no branch, no mc start):
- Condition: ex_is_load & ex_reg_write & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- Response: pc_hold=ifid_hold=1, idex_clear=1 for one cycle. No state change.

Branch (RUN or MC_DONE):
- ex_branch_taken=1 gives ifid_clear=idex_clear=1 with all holds forced 0.
- Branch has priority over load-use.

Simultaneous ex_branch_taken and ex_mc_start in RUN:
- Protocol violation; the bench asserts on it.
- RTL response: branch flush wins and the FSM stays in RUN.

exmem_hold: none. EX/MEM hold is tied 0 at top level; MEM/WB is never stalled.

Optional Feature:
HAZARD_PERF_EN
- Defined:
  - stall_cycles increments on each cycle with pc_hold=1.
  - flush_count increments on each branch flush.
  - Both are 32-bit, wrap at 2^32-1 -> 0, and are zeroed by clear_n.
- Undefined: both ports are driven constant 0 and no counter flops exist.

Decomposition:
- Package hazard_pkg:
  - state enum {RUN, MC_BUSY, MC_DONE};
  - REG_ADDR_W default;
  - MC_CNT_W = clog2(MC_CYCLES).
- Sub-module load_use_detect: combinational comparator producing the load-use stall bit; instantiated once.

Test Plan:
- Load-use: ex_is_load=1, ex_reg_write=1, ex_rd=5, id_rs2=5, id_rs2_used=1 -> one cycle of pc_hold=ifid_hold=idex_clear=1; the following cycle (load in MEM) all 0.
- Load to x0: same as load-use but ex_rd=0, id_rs1=0, id_rs1_used=1 -> no stall.
- Branch flush: ex_branch_taken=1 for one cycle -> ifid_clear=idex_clear=1, holds 0; flush_count 0->1 when HAZARD_PERF_EN.
- Branch plus load-use in the same cycle -> flush only, pc_hold=0.
- Multi-cycle, MC_CYCLES=4, ex_mc_start held high 4 cycles:
  - cycles 0-2: holds=1, exmem_clear=1, mc_busy=1;
  - cycle 3: MC_DONE, all 0;
  - cycle 4: RUN;
  - stall_cycles=3.
- Reset mid-op: clear_n=0 during MC_BUSY -> next cycle state RUN, holds 0, all clears 1 while low; ex_mc_start=0 after release -> no holds.
